// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the keypad scanner front end.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHold,
    StRelease
  } keypad_state_e;

  localparam logic [3:0] COLS_IDLE = 4'b1111;
  localparam logic [3:0] ROW_FIRST = 4'b0111;

  // Exactly one zero bit: a single key on a single row or column line.
  function automatic logic is_one_cold(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  // Walking zero steps one place to the right and wraps.
  function automatic logic [3:0] rotate_row(input logic [3:0] r);
    return {r[0], r[3:1]};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-facing and encoder-facing signals of the scanner.
interface keypad_scanner_if;

  logic [3:0] ColumnsIn;
  logic [3:0] Rows;
  logic [3:0] Columns;
  logic       KeyDown;
  logic       KeyPress;

  modport master (
    input  ColumnsIn,
    output Rows,
    output Columns,
    output KeyDown,
    output KeyPress
  );

  modport slave (
    output ColumnsIn,
    input  Rows,
    input  Columns,
    input  KeyDown,
    input  KeyPress
  );

endinterface

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every SCAN_DIV cycles.
module keypad_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic Clock,
  input  logic Reset,
  output logic tick
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntW'(SCAN_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row scanner with column synchronizer and press/release debouncing; the
// encoder only ever sees a settled one-cold column pattern or all-ones.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  keypad_scanner_if.master  kp
);

  localparam int unsigned CntW      = $clog2(DEBOUNCE_CNT + 1);
  localparam bit          SingleHit = (DEBOUNCE_CNT == 1);

  keypad_state_e        state_q;
  logic [1:0][3:0]      sync_q;
  logic [3:0]           rows_q, cols_q, cand_q;
  logic                 key_down_q, key_press_q;
  logic [CntW-1:0]      cnt_q;

  logic                 tick;
  logic [3:0]           sample;
  logic [CntW-1:0]      cnt_inc;
  logic                 cnt_done;

  keypad_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_gen (
    .Clock (Clock),
    .Reset (Reset),
    .tick  (tick)
  );

  assign sample   = sync_q[1];
  assign cnt_inc  = cnt_q + CntW'(1);
  assign cnt_done = (cnt_inc == CntW'(DEBOUNCE_CNT));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StScan;
      sync_q      <= {COLS_IDLE, COLS_IDLE};
      rows_q      <= ROW_FIRST;
      cols_q      <= COLS_IDLE;
      cand_q      <= COLS_IDLE;
      key_down_q  <= 1'b0;
      key_press_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_q      <= {sync_q[0], kp.ColumnsIn};
      key_press_q <= 1'b0;
      if (tick) begin
        case (state_q)
          StScan: begin
            if (is_one_cold(sample)) begin
              cand_q <= sample;
              cnt_q  <= CntW'(1);
              if (SingleHit) begin
                state_q     <= StHold;
                cols_q      <= sample;
                key_down_q  <= 1'b1;
                key_press_q <= 1'b1;
              end else begin
                state_q <= StDebounce;
              end
            end else begin
              rows_q <= rotate_row(rows_q);
            end
          end
          StDebounce: begin
            if (sample == cand_q) begin
              if (cnt_done) begin
                state_q     <= StHold;
                cols_q      <= cand_q;
                key_down_q  <= 1'b1;
                key_press_q <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= StScan;
              rows_q  <= rotate_row(rows_q);
            end
          end
          StHold: begin
            if (sample != cand_q) begin
              cnt_q <= CntW'(1);
              if (SingleHit) begin
                state_q    <= StScan;
                cols_q     <= COLS_IDLE;
                key_down_q <= 1'b0;
                rows_q     <= rotate_row(rows_q);
              end else begin
                state_q <= StRelease;
              end
            end
          end
          StRelease: begin
            // A bounce back to the held key resumes HOLD without a new press.
            if (sample == cand_q) begin
              state_q <= StHold;
            end else if (cnt_done) begin
              state_q    <= StScan;
              cols_q     <= COLS_IDLE;
              key_down_q <= 1'b0;
              rows_q     <= rotate_row(rows_q);
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: state_q <= StScan;
        endcase
      end
    end
  end

  assign kp.Rows     = rows_q;
  assign kp.Columns  = cols_q;
  assign kp.KeyDown  = key_down_q;
  assign kp.KeyPress = key_press_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Upstream stage of the keypad key encoder. Drives the 4x4 keypad rows with an active-low walking zero and synchronizes and debounces the raw active-low column lines. Freezes the row while a key is held. Presents a stable {Columns, Rows} pair to the encoder, so the encoder only sees a one-cold/one-cold pattern for a clean, debounced single key, and sees Columns=4'b1111 (no key) at all other times.

Parameters:
SCAN_DIV, 50000, Clock cycles per scan tick (row dwell / sample period); must be >= 2.
DEBOUNCE_CNT, 4, consecutive matching tick samples needed to accept a press or a release; must be >= 1.

Ports:
Clock  input  1  system clock
Reset  input  1  reset
ColumnsIn  input  4  raw keypad columns, asynchronous, active-low, pulled up
Rows  output  4  row drive to keypad and encoder, active-low one-cold
Columns  output  4  debounced columns to encoder, 4'b1111 when no valid key
KeyDown  output  1  high while a debounced key is held
KeyPress  output  1  one-cycle pulse on press acceptance

Behaviour:
- Clock is Clock; Reset is asynchronous, active-high (Reset). All state is in one clock domain.
- Reset values: Rows=4'b0111, Columns=4'b1111, KeyDown=0, KeyPress=0, state=SCAN, tick counter=0, debounce counter=0, candidate=4'b1111, both synchronizer stages=4'b1111.
- Synchronizer: two flops on ColumnsIn. The output is called "sample" below. Latency is 2 cycles.
- Tick: a free-running counter runs 0..SCAN_DIV-1. tick=1 for one cycle when the count equals SCAN_DIV-1, then the counter wraps to 0. The counter is never held or cleared except by Reset.
- All state transitions below occur only on tick cycles. The sample is taken in the tick cycle.
- "Valid" means the sample has exactly one zero bit. Samples of 4'b1111 or with multiple zeros are invalid.
- SCAN state:
  - On tick with a valid sample: candidate<=sample, count<=1, go to DEBOUNCE. Rows is not changed.
  - Otherwise rotate Rows right: 0111 -> 1011 -> 1101 -> 1110 -> 0111.
  - If DEBOUNCE_CNT==1, go directly to HOLD with the HOLD entry actions.
- DEBOUNCE state (Rows frozen):
  - On tick with sample==candidate: count++.
  - When count reaches DEBOUNCE_CNT, go to HOLD. In the same cycle: Columns<=candidate, KeyDown<=1, KeyPress<=1 for exactly one cycle.
  - On tick with sample!=candidate: go to SCAN and rotate Rows once.
- HOLD state (Rows frozen, Columns=candidate):
  - On tick with sample==candidate: stay.
  - On tick with any other sample: count<=1 and go to RELEASE. If DEBOUNCE_CNT==1, apply the release actions immediately.
- RELEASE state (Rows frozen, Columns and KeyDown still asserted):
  - On tick with sample!=candidate: count++.
  - When count reaches DEBOUNCE_CNT: Columns<=4'b1111, KeyDown<=0, go to SCAN, rotate Rows once.
  - On tick with sample==candidate: return to HOLD with no output change and no second KeyPress.
- KeyPress is 0 in every cycle except the HOLD-entry cycle.
- Press latency from a stable press on the current row: DEBOUNCE_CNT ticks, plus 0..SCAN_DIV-1 cycles of tick alignment, plus 2 synchronizer cycles.
- Columns is a registered output and changes only at HOLD entry and at release acceptance. The encoder therefore never sees a bouncing pattern.
- Reset mid-operation, in any state, immediately restores all reset values. No KeyPress is issued.

Decomposition:
- Shared package keypad_pkg:
  - State enum {SCAN, DEBOUNCE, HOLD, RELEASE}.
  - Constants COLS_IDLE=4'b1111 and ROW_FIRST=4'b0111.
  - One-cold check function.
- One sub-module, keypad_tick_gen:
  - Parameter SCAN_DIV.
  - Inputs Clock, Reset.
  - Output tick.
  - Counter width is $clog2(SCAN_DIV).

Test Plan:
The bench runs SCAN_DIV=4 and DEBOUNCE_CNT=3. A keypad model drives ColumnsIn = col_pattern when Rows==row_pattern, else 4'b1111.
1. Reset, no key -> Rows=0111, Columns=1111, KeyDown=0. Rows then steps 1011, 1101, 1110, 0111 at 4-cycle intervals, and KeyPress never asserts.
2. Hold key5 (row 1011, col 1011) -> Rows freezes at 1011 after 3 matching ticks. Columns=1011, KeyDown=1, KeyPress high for exactly 1 cycle. The encoder outputs tens=0, ones=5, Found=1.
3. Key D (col 1110, row 1110) bounces once during DEBOUNCE (1 tick at 1111) -> no KeyPress. Scanning resumes with a rotation, then the key is later accepted normally with one KeyPress.
4. From HOLD on key5, release with one bounce tick back to 1011 -> returns to HOLD with no new KeyPress. After 3 consecutive 1111 ticks: Columns=1111, KeyDown=0, Rows advances to 1101.
5. Two columns low on row 0111 (ColumnsIn=0011) -> treated as invalid. No DEBOUNCE entry, Columns stays 1111, rotation continues.
6. Assert Reset while in HOLD on key star (row 1110, col 0111) -> immediately Rows=0111, Columns=1111, KeyDown=0, KeyPress=0. After Reset drops, scanning restarts at 0111.
